// File: rtl/isolator_spi_pkg.sv
// Shared types and sizing helpers for the isolator-side serial responder.
package isolator_spi_pkg;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_e;

  localparam int DEF_ADDR_BITS = 7;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_NUM_REGS  = 16;

  // One R/W bit, then the address field, then the data field.
  localparam int FRAME_BITS = 1 + DEF_ADDR_BITS + DEF_DATA_BITS;

  // The bit counter indexes every sck rise of a frame, so it must hold FRAME_BITS-1.
  function automatic int cnt_bits(input int addr_bits, input int data_bits);
    return $clog2(1 + addr_bits + data_bits);
  endfunction

endpackage

// File: rtl/isolator_spi_responder_sync_edge_detect.sv
// Two-flop synchronizer with one extra delayed copy for single-cycle rise/fall pulses.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Resetting to 0 means a low cs_n at reset release is not seen as a fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/isolator_spi_responder.sv
// Serial control-link responder: framed read/write commands into a local register bank.
// Define ISOLATOR_SPI_WR_FIFO_EN to report each completed write on the wr_* handshake port.
module isolator_spi_responder
  import isolator_spi_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int NUM_REGS  = DEF_NUM_REGS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sck,
  input  logic                          cs_n,
  input  logic                          mdi,
  output logic                          mdo,
  output logic [NUM_REGS*DATA_BITS-1:0] regs_out,
  input  logic                          wr_ready,
  output logic                          wr_enable,
  output logic [ADDR_BITS+DATA_BITS-1:0] wr_data,
  output logic                          wr_ovf
);

  localparam int CNT_W = cnt_bits(ADDR_BITS, DATA_BITS);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic sck_level, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mdi_level, mdi_rise, mdi_fall;

  sync_edge_detect u_sync_sck (
    .clk(clk), .reset(reset), .din(sck),
    .level(sck_level), .rise(sck_rise), .fall(sck_fall)
  );

  sync_edge_detect u_sync_cs (
    .clk(clk), .reset(reset), .din(cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  sync_edge_detect u_sync_mdi (
    .clk(clk), .reset(reset), .din(mdi),
    .level(mdi_level), .rise(mdi_rise), .fall(mdi_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{sck_level, cs_rise, mdi_rise, mdi_fall};

  state_e                 state;
  logic                   is_read;
  logic [CNT_W-1:0]       bit_cnt;
  logic [ADDR_BITS-1:0]   addr;
  logic [ADDR_BITS-1:0]   addr_next;
  logic [DATA_BITS-1:0]   rx_shift;
  logic [DATA_BITS-1:0]   rx_next;
  logic [DATA_BITS-1:0]   tx_shift;
  logic [DATA_BITS-1:0]   rd_value;
  logic                   commit_valid;
  logic [ADDR_BITS-1:0]   commit_addr;
  logic [DATA_BITS-1:0]   commit_data;
  logic                   commit_in_range;
  logic [DATA_BITS-1:0]   regs [NUM_REGS];

  always_comb begin
    addr_next = {addr[ADDR_BITS-2:0], mdi_level};
    rx_next   = {rx_shift[DATA_BITS-2:0], mdi_level};
    rd_value  = '0;
    if (int'(addr_next) < NUM_REGS)
      rd_value = regs[addr_next[IDX_W-1:0]];
  end

  // bit_cnt holds the index within the frame of the next sck rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      is_read      <= 1'b0;
      bit_cnt      <= '0;
      addr         <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      mdo          <= 1'b0;
      commit_valid <= 1'b0;
      commit_addr  <= '0;
      commit_data  <= '0;
    end else begin
      commit_valid <= 1'b0;
      if (cs_level) begin
        state   <= IDLE;
        mdo     <= 1'b0;
        bit_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            mdo <= 1'b0;
            if (cs_fall) begin
              state   <= CMD;
              bit_cnt <= '0;
            end
          end
          CMD: begin
            mdo <= 1'b0;
            if (sck_rise) begin
              is_read <= mdi_level;
              bit_cnt <= CNT_W'(1);
              state   <= ADDR;
            end
          end
          ADDR: begin
            mdo <= 1'b0;
            if (sck_rise) begin
              addr    <= addr_next;
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(ADDR_BITS)) begin
                tx_shift <= rd_value;
                state    <= DATA;
              end
            end
          end
          DATA: begin
            // Read data leaves on falls so the FPGA samples a settled bit on the next rise.
            if (is_read && sck_fall) begin
              mdo      <= tx_shift[DATA_BITS-1];
              tx_shift <= {tx_shift[DATA_BITS-2:0], 1'b0};
            end
            if (sck_rise) begin
              rx_shift <= rx_next;
              bit_cnt  <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(ADDR_BITS + DATA_BITS)) begin
                state <= DONE;
                mdo   <= 1'b0;
                if (!is_read) begin
                  commit_valid <= 1'b1;
                  commit_addr  <= addr;
                  commit_data  <= rx_next;
                end
              end
            end
          end
          DONE: mdo <= 1'b0;
          default: begin
            state <= IDLE;
            mdo   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign commit_in_range = int'(commit_addr) < NUM_REGS;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (commit_valid && commit_in_range) begin
      regs[commit_addr[IDX_W-1:0]] <= commit_data;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_out[g*DATA_BITS +: DATA_BITS] = regs[g];
  end

`ifdef ISOLATOR_SPI_WR_FIFO_EN
  // A commit on the same cycle as a handshake reuses the slot being freed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_enable <= 1'b0;
      wr_data   <= '0;
      wr_ovf    <= 1'b0;
    end else if (commit_valid) begin
      if (!wr_enable || wr_ready) begin
        wr_enable <= 1'b1;
        wr_data   <= {commit_addr, commit_data};
      end else begin
        wr_ovf <= 1'b1;
      end
    end else if (wr_enable && wr_ready) begin
      wr_enable <= 1'b0;
      wr_data   <= '0;
    end
  end
`else
  logic unused_ready;
  assign unused_ready = wr_ready;
  assign wr_enable    = 1'b0;
  assign wr_data      = '0;
  assign wr_ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_isolator_spi_responder.sv
// Directed bench for isolator_spi_responder: table of frames plus hand-written corner sequences.
module tb_isolator_spi_responder;
  import isolator_spi_pkg::*;

  logic         clk;
  logic         reset;
  logic         sck;
  logic         cs_n;
  logic         mdi;
  logic         mdo;
  logic [127:0] regs_out;
  logic         wr_ready;
  logic         wr_enable;
  logic [14:0]  wr_data;
  logic         wr_ovf;

  int checks;
  int failures;

  logic [7:0] model [16];

  isolator_spi_responder dut (
    .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .mdi(mdi), .mdo(mdo),
    .regs_out(regs_out), .wr_ready(wr_ready), .wr_enable(wr_enable),
    .wr_data(wr_data), .wr_ovf(wr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rd;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [127:0] modelFlat();
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[i*8 +: 8] = model[i];
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic shiftBit(input logic b);
    mdi = b;
    #80;
    sck = 1'b1;
    #80;
    sck = 1'b0;
  endtask

  // Drives one frame (optionally truncated); collects mdo before each data rise.
  task automatic applyStimulus(input logic rd, input logic [6:0] a, input logic [7:0] d,
                               input int nbits, output logic [7:0] rdata, output logic mdo_bad);
    logic [15:0] word;
    word    = {rd, a, d};
    rdata   = '0;
    mdo_bad = 1'b0;
    cs_n    = 1'b0;
    #80;
    for (int i = 0; i < nbits; i++) begin
      mdi = word[15-i];
      #80;
      if (i >= 8) rdata = {rdata[6:0], mdo};
      else if (mdo !== 1'b0) mdo_bad = 1'b1;
      sck = 1'b1;
      #80;
      sck = 1'b0;
    end
    #80;
    if (mdo !== 1'b0) mdo_bad = 1'b1;
    cs_n = 1'b1;
    mdi  = 1'b0;
    #160;
  endtask

  task automatic handshakeWindow(output int count, output logic [14:0] data);
    count    = 0;
    data     = '0;
    wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (wr_enable && wr_ready) begin
        count++;
        data = wr_data;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0]  rdata;
    logic        bad;
    logic [15:0] word;
    int          hs_count;
    logic [14:0] hs_data;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    sck      = 1'b0;
    cs_n     = 1'b1;
    mdi      = 1'b0;
    wr_ready = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;

    vecs[0] = '{1'b0, 7'd5,    8'h3C, 8'h00};
    vecs[1] = '{1'b1, 7'd5,    8'h00, 8'h3C};
    vecs[2] = '{1'b0, 7'd0,    8'h81, 8'h00};
    vecs[3] = '{1'b0, 7'd15,   8'h7E, 8'h00};
    vecs[4] = '{1'b1, 7'd15,   8'h00, 8'h7E};
    vecs[5] = '{1'b1, 7'd0,    8'h00, 8'h81};
    vecs[6] = '{1'b1, 7'h40,   8'h00, 8'h00};
    vecs[7] = '{1'b1, 7'd3,    8'h00, 8'hA5};
    vecs[8] = '{1'b1, 7'd9,    8'h00, 8'h00};

    repeat (3) @(negedge clk);
    checkOutput("reset_mdo", 128'(mdo), 128'(0));
    checkOutput("reset_regs", regs_out, 128'(0));
    checkOutput("reset_wr_enable", 128'(wr_enable), 128'(0));
    checkOutput("reset_state", 128'(dut.state), 128'(IDLE));
    reset = 1'b0;
    #160;

    // Write addr 3 = 0xA5, timing the commit against the final sck rise.
    word = {1'b0, 7'd3, 8'hA5};
    cs_n = 1'b0;
    #80;
    for (int i = 0; i < 15; i++) shiftBit(word[15-i]);
    mdi = word[0];
    #80;
    sck = 1'b1;
    #30;
    checkOutput("commit_not_before_4th_edge", regs_out, 128'(0));
    #10;
    model[3] = 8'hA5;
    checkOutput("commit_at_4th_edge", regs_out, modelFlat());
    #40;
    sck = 1'b0;
    #80;
    cs_n = 1'b1;
    #160;

    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].rd, vecs[v].addr, vecs[v].data, FRAME_BITS, rdata, bad);
      if (!vecs[v].rd && vecs[v].addr < 7'd16) model[vecs[v].addr[3:0]] = vecs[v].data;
      if (vecs[v].rd) checkOutput($sformatf("vec%0d_read_data", v), 128'(rdata), 128'(vecs[v].exp_rd));
      checkOutput($sformatf("vec%0d_mdo_outside_data", v), 128'(bad), 128'(0));
      checkOutput($sformatf("vec%0d_regs", v), regs_out, modelFlat());
    end

    // Truncated write: cs_n rises after 10 of 16 bits.
    applyStimulus(1'b0, 7'd1, 8'h55, 10, rdata, bad);
    checkOutput("partial_state", 128'(dut.state), 128'(IDLE));
    checkOutput("partial_regs", regs_out, modelFlat());
    applyStimulus(1'b0, 7'd1, 8'h66, FRAME_BITS, rdata, bad);
    model[1] = 8'h66;
    checkOutput("after_partial_regs", regs_out, modelFlat());
    applyStimulus(1'b1, 7'd1, 8'h00, FRAME_BITS, rdata, bad);
    checkOutput("after_partial_read", 128'(rdata), 128'(8'h66));

    // Out-of-range write, with the sink stalled.
    wr_ready = 1'b0;
    applyStimulus(1'b0, 7'h40, 8'hFF, FRAME_BITS, rdata, bad);
    checkOutput("oor_regs", regs_out, modelFlat());
`ifdef ISOLATOR_SPI_WR_FIFO_EN
    checkOutput("oor_wr_enable", 128'(wr_enable), 128'(1));
    checkOutput("oor_wr_data", 128'(wr_data), 128'(15'h40FF));
    checkOutput("oor_wr_ovf", 128'(wr_ovf), 128'(0));
    handshakeWindow(hs_count, hs_data);
    checkOutput("oor_hs_count", 128'(hs_count), 128'(1));
    checkOutput("oor_hs_data", 128'(hs_data), 128'(15'h40FF));
    checkOutput("oor_drained", 128'(wr_enable), 128'(0));

    wr_ready = 1'b0;
    applyStimulus(1'b0, 7'd2, 8'h11, FRAME_BITS, rdata, bad);
    model[2] = 8'h11;
    checkOutput("ovf_clear_after_first", 128'(wr_ovf), 128'(0));
    applyStimulus(1'b0, 7'd4, 8'h22, FRAME_BITS, rdata, bad);
    model[4] = 8'h22;
    checkOutput("ovf_set", 128'(wr_ovf), 128'(1));
    checkOutput("ovf_held_data", 128'(wr_data), 128'(15'h0211));
    checkOutput("ovf_regs", regs_out, modelFlat());
    handshakeWindow(hs_count, hs_data);
    checkOutput("ovf_hs_count", 128'(hs_count), 128'(1));
    checkOutput("ovf_hs_data", 128'(hs_data), 128'(15'h0211));
    checkOutput("ovf_sticky", 128'(wr_ovf), 128'(1));
`else
    checkOutput("nofifo_wr_enable", 128'(wr_enable), 128'(0));
    checkOutput("nofifo_wr_data", 128'(wr_data), 128'(0));
    checkOutput("nofifo_wr_ovf", 128'(wr_ovf), 128'(0));
    handshakeWindow(hs_count, hs_data);
    checkOutput("nofifo_hs_count", 128'(hs_count), 128'(0));
`endif

    // Reset in the middle of reading addr 5 (0x3C), once mdo is driving bit 5 = 1.
    word = {1'b1, 7'd5, 8'h00};
    cs_n = 1'b0;
    #80;
    for (int i = 0; i < 10; i++) shiftBit(word[15-i]);
    #80;
    checkOutput("midread_mdo", 128'(mdo), 128'(1));
    reset = 1'b1;
    #1;
    checkOutput("midread_reset_mdo", 128'(mdo), 128'(0));
    checkOutput("midread_reset_regs", regs_out, 128'(0));
    #9;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    for (int i = 0; i < 6; i++) shiftBit(1'b1);
    #80;
    checkOutput("post_reset_state", 128'(dut.state), 128'(IDLE));
    checkOutput("post_reset_mdo", 128'(mdo), 128'(0));
    checkOutput("post_reset_regs", regs_out, 128'(0));
    cs_n = 1'b1;
    #160;
    wr_ready = 1'b1;
    applyStimulus(1'b0, 7'd7, 8'h5A, FRAME_BITS, rdata, bad);
    model[7] = 8'h5A;
    checkOutput("post_reset_write", regs_out, modelFlat());
    applyStimulus(1'b1, 7'd7, 8'h00, FRAME_BITS, rdata, bad);
    checkOutput("post_reset_read", 128'(rdata), 128'(8'h5A));
    checkOutput("post_reset_mdo_outside", 128'(bad), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
